// File: rtl/mat_seq_pkg.sv
// Shared types and defaults for the matrix-multiply sequencer and its datapath top.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mat_seq_pkg;

  // Defaults shared with the datapath top
  localparam int N_DEF        = 2;
  localparam int LAT_DEF      = 3;
  localparam int IMAG_OFS_DEF = 8;
  localparam int ADDR_W_DEF   = 4;
  localparam int RAM_AW_DEF   = 2;

  // Tag write-address field is sized for the largest result RAM we expect
  localparam int WADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic               valid;
    logic               first;
    logic               last;
    logic [WADDR_W-1:0] waddr;
  } seq_tag_t;

  // Row-major linear index of (row, col) in an n-wide matrix
  function automatic int unsigned lin_idx(input int unsigned row,
                                          input int unsigned col,
                                          input int unsigned n);
    return row * n + col;
  endfunction

endpackage

// File: rtl/mat_addr_seq_if.sv
// Control bundle between the multiply sequencer and the ROM/accumulator/SPRAM datapath.
// Latency: n/a (wiring only).
// Backpressure: none; the datapath is a fixed-latency pipeline that always accepts.
interface mat_addr_seq_if
  import mat_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RAM_AW = RAM_AW_DEF
);

  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] addr_am1;
  logic [ADDR_W-1:0] addr_bm1;
  logic [ADDR_W-1:0] addr_am2;
  logic [ADDR_W-1:0] addr_bm2;
  logic              acc_en;
  logic              acc_load;
  logic              we;
  logic [RAM_AW-1:0] addr_wr;

  // Sequencer side
  modport master (
    input  start,
    output busy, done,
    output addr_am1, addr_bm1, addr_am2, addr_bm2,
    output acc_en, acc_load, we, addr_wr
  );

  // Datapath / controller side
  modport slave (
    output start,
    input  busy, done,
    input  addr_am1, addr_bm1, addr_am2, addr_bm2,
    input  acc_en, acc_load, we, addr_wr
  );

endinterface

// File: rtl/seq_tag_delay.sv
// Tag delay line that lines up each issued product term with the datapath output.
// Latency: stage 1 holds the term currently addressed; taps at LAT and LAT+1.
// Backpressure: none; shifts every clock.
module seq_tag_delay
  import mat_seq_pkg::*;
#(
  parameter int LAT = LAT_DEF
) (
  input  logic     clk,
  input  logic     rst,
  input  seq_tag_t push_tag,
  output seq_tag_t tap_lat,
  output seq_tag_t tap_lat1
);

  // stage[s] carries the tag of the term addressed s cycles ago (0 = this cycle)
  seq_tag_t stage [LAT+1];

  // Shift tags one stage per clock; reset only needs to kill the valid bits
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s <= LAT; s++) begin
        stage[s].valid <= 1'b0;
      end
    end else begin
      stage[0] <= push_tag;
      for (int s = 1; s <= LAT; s++) begin
        stage[s] <= stage[s-1];
      end
    end
  end

  assign tap_lat  = stage[LAT-1];
  assign tap_lat1 = stage[LAT];

endmodule

// File: rtl/mat_addr_seq.sv
// Sequencer for C = A*B on NxN complex matrices: walks (i,k,j), drives ROM addresses, tags terms.
// Latency: addresses one clock after start; acc_en LAT clocks after address; write one clock later.
// Backpressure: none; start is ignored while a multiply is in flight.
module mat_addr_seq
  import mat_seq_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int RAM_AW   = RAM_AW_DEF,
  parameter int IMAG_OFS = IMAG_OFS_DEF,
  parameter int LAT      = LAT_DEF
) (
  input  logic           clk,
  input  logic           rst,
  mat_addr_seq_if.master bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int DW = $clog2(LAT + 2);

  typedef logic [CW-1:0] idx_t;

  localparam idx_t LAST_IDX = CW'(N - 1);

  seq_state_t        state, state_nxt;
  idx_t              i_q, k_q, j_q;
  idx_t              i_n, k_n, j_n;
  logic [DW-1:0]     drain_q, drain_n;
  logic              last_term;
  logic [ADDR_W-1:0] a_idx_n, b_idx_n;
  seq_tag_t          push_tag, tap_acc, tap_wr;
  logic              unused_tag_bits;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and next (i,k,j): j innermost, then k, then i
  always_comb begin
    state_nxt = state;
    i_n       = i_q;
    k_n       = k_q;
    j_n       = j_q;
    drain_n   = drain_q;
    last_term = (i_q == LAST_IDX) && (k_q == LAST_IDX) && (j_q == LAST_IDX);
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = ISSUE;
          i_n       = '0;
          k_n       = '0;
          j_n       = '0;
        end
      end
      ISSUE: begin
        if (last_term) begin
          state_nxt = DRAIN;
          drain_n   = '0;
        end else if (j_q == LAST_IDX) begin
          j_n = '0;
          if (k_q == LAST_IDX) begin
            k_n = '0;
            i_n = i_q + CW'(1);
          end else begin
            k_n = k_q + CW'(1);
          end
        end else begin
          j_n = j_q + CW'(1);
        end
      end
      DRAIN: begin
        // LAT+1 cycles lets the last term reach the write tap
        if (drain_q == DW'(LAT)) begin
          state_nxt = DONE;
        end else begin
          drain_n = drain_q + DW'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Loop counters and drain counter
  always_ff @(posedge clk) begin
    if (rst) begin
      i_q     <= '0;
      k_q     <= '0;
      j_q     <= '0;
      drain_q <= '0;
    end else begin
      i_q     <= i_n;
      k_q     <= k_n;
      j_q     <= j_n;
      drain_q <= drain_n;
    end
  end

  // Address indices and the tag for the term that will be addressed next cycle
  always_comb begin
    a_idx_n  = ADDR_W'(lin_idx(32'(i_n), 32'(j_n), N));
    b_idx_n  = ADDR_W'(lin_idx(32'(j_n), 32'(k_n), N));
    push_tag = '0;
    if (state_nxt == ISSUE) begin
      push_tag.valid = 1'b1;
      push_tag.first = (j_n == '0);
      push_tag.last  = (j_n == LAST_IDX);
      push_tag.waddr = WADDR_W'(lin_idx(32'(i_n), 32'(k_n), N));
    end
  end

  // ROM addresses: live term while issuing, otherwise parked on element 0 of each plane
  always_ff @(posedge clk) begin
    if (rst || (state_nxt != ISSUE)) begin
      bus.addr_am1 <= '0;
      bus.addr_bm1 <= ADDR_W'(IMAG_OFS);
      bus.addr_am2 <= '0;
      bus.addr_bm2 <= ADDR_W'(IMAG_OFS);
    end else begin
      bus.addr_am1 <= a_idx_n;
      bus.addr_bm1 <= ADDR_W'(IMAG_OFS) + a_idx_n;
      bus.addr_am2 <= b_idx_n;
      bus.addr_bm2 <= ADDR_W'(IMAG_OFS) + b_idx_n;
    end
  end

  // Status flags registered from the next state so they line up with the addresses
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.busy <= (state_nxt == ISSUE) || (state_nxt == DRAIN);
      bus.done <= (state_nxt == DONE);
    end
  end

  seq_tag_delay #(
    .LAT(LAT)
  ) u_tag_delay (
    .clk      (clk),
    .rst      (rst),
    .push_tag (push_tag),
    .tap_lat  (tap_acc),
    .tap_lat1 (tap_wr)
  );

  // Only some tag fields matter at each tap
  assign unused_tag_bits = ^{tap_acc.last, tap_acc.waddr, tap_wr.first};

  // Accumulator and SPRAM controls; addr_wr only moves when a write happens
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.acc_en   <= 1'b0;
      bus.acc_load <= 1'b0;
      bus.we       <= 1'b0;
      bus.addr_wr  <= '0;
    end else begin
      bus.acc_en   <= tap_acc.valid;
      bus.acc_load <= tap_acc.valid & tap_acc.first;
      bus.we       <= tap_wr.valid & tap_wr.last;
      if (tap_wr.valid && tap_wr.last) begin
        bus.addr_wr <= tap_wr.waddr[RAM_AW-1:0];
      end
    end
  end

endmodule
